// File: rtl/minv_sched.sv
`default_nettype none
// ============================================================================
// Module      : minv_sched
// Description : Round-robin scheduler sharing one modular-inversion core
//               (a^-1 mod p) among NREQ requesters. Screens illegal operands
//               locally, supervises the core with a watchdog and routes the
//               result back to the granted requester.
// Revision    : 1.0 - initial release
// ============================================================================
module minv_sched #(
    parameter int NREQ    = 4,
    parameter int W       = 256,
    parameter int TIMEOUT = 4096
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*W-1:0]   req_a,
    input  logic [NREQ*W-1:0]   req_p,
    output logic [NREQ-1:0]     rsp_valid,
    input  logic [NREQ-1:0]     rsp_ready,
    output logic [W-1:0]        rsp_inv,
    output logic                rsp_err,
    output logic                core_start,
    output logic                core_abort,
    output logic [W-1:0]        core_a,
    output logic [W-1:0]        core_p,
    input  logic                core_done,
    input  logic [W-1:0]        core_inv,
    input  logic                core_err
);

    localparam int              c_idx_w   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int              c_wd_w    = $clog2(TIMEOUT);
    localparam logic [c_wd_w-1:0] c_wd_last = c_wd_w'(TIMEOUT - 1);
    localparam logic [W-1:0]    c_p_min   = W'(3);
    localparam logic [NREQ-1:0] c_one_hot = NREQ'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CHECK = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic [c_idx_w-1:0]   r_rr_ptr;
    logic [c_idx_w-1:0]   r_winner;
    logic [c_idx_w-1:0]   w_win_idx;
    logic [c_idx_w-1:0]   w_ptr_next;
    logic                 w_any;
    logic                 w_grant;
    logic                 w_illegal;
    logic                 w_timeout;
    logic [c_wd_w-1:0]    r_wd;
    logic [W-1:0]         r_core_a;
    logic [W-1:0]         r_core_p;
    logic [W-1:0]         r_rsp_inv;
    logic                 r_rsp_err;

    // Round-robin search: first pending request at or after the pointer, wrapping
    always_comb begin
        int j;
        j         = 0;
        w_any     = 1'b0;
        w_win_idx = '0;
        // Walk from the farthest offset down so the closest hit is written last
        for (int k = NREQ - 1; k >= 0; k--) begin
            j = int'(r_rr_ptr) + k;
            if (j >= NREQ) begin
                j = j - NREQ;
            end
            if (req_valid[j]) begin
                w_any     = 1'b1;
                w_win_idx = c_idx_w'(j);
            end
        end
    end

    assign w_ptr_next = (int'(w_win_idx) == NREQ - 1) ? '0 : w_win_idx + 1'b1;

    // Operands come from the latches that also feed the core
    assign w_illegal = (r_core_a == '0) || (r_core_p < c_p_min) ||
                       !r_core_p[0] || (r_core_a >= r_core_p);
    assign w_timeout = (r_wd == c_wd_last);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic and single-cycle control pulses
    always_comb begin
        w_next_state = r_state;
        w_grant      = 1'b0;
        core_start   = 1'b0;
        core_abort   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_grant      = 1'b1;
                    w_next_state = S_CHECK;
                end
            end
            S_CHECK: begin
                w_next_state = w_illegal ? S_RESP : S_ISSUE;
            end
            S_ISSUE: begin
                core_start   = 1'b1;
                w_next_state = S_WAIT;
            end
            S_WAIT: begin
                // A completion in the timeout cycle takes priority over the abort
                if (core_done) begin
                    w_next_state = S_RESP;
                end else if (w_timeout) begin
                    core_abort   = 1'b1;
                    w_next_state = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready[r_winner]) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Grant latch, watchdog and response capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr  <= '0;
            r_winner  <= '0;
            r_wd      <= '0;
            r_core_a  <= '0;
            r_core_p  <= '0;
            r_rsp_inv <= '0;
            r_rsp_err <= 1'b0;
        end else begin
            if (w_grant) begin
                r_core_a <= req_a[int'(w_win_idx) * W +: W];
                r_core_p <= req_p[int'(w_win_idx) * W +: W];
                r_winner <= w_win_idx;
                r_rr_ptr <= w_ptr_next;
            end
            case (r_state)
                S_CHECK: begin
                    if (w_illegal) begin
                        r_rsp_inv <= '0;
                        r_rsp_err <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    r_wd <= '0;
                end
                S_WAIT: begin
                    r_wd <= r_wd + 1'b1;
                    if (core_done) begin
                        r_rsp_inv <= core_err ? '0 : core_inv;
                        r_rsp_err <= core_err;
                    end else if (w_timeout) begin
                        r_rsp_inv <= '0;
                        r_rsp_err <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Accept pulse is forced low while reset is asserted
    assign req_ready = (w_grant && rst_n) ? (c_one_hot << w_win_idx) : '0;
    assign rsp_valid = (r_state == S_RESP) ? (c_one_hot << r_winner) : '0;
    assign rsp_inv   = r_rsp_inv;
    assign rsp_err   = r_rsp_err;
    assign core_a    = r_core_a;
    assign core_p    = r_core_p;

endmodule
`default_nettype wire
